// File: rtl/patch_streamer.sv
// Raster-order binary pixel stream to KxK patch stream for the mac array.
// Keeps K-1 lines of history plus the KxK window and emits one patch per valid top-left position.
module patch_streamer #(
  parameter int K     = 3,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [K*K-1:0]   patch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_row,
  output logic [15:0]      out_col,
  output logic             out_last
);

  localparam int          LB_W     = (K - 1) * IMG_W;
  localparam logic [15:0] LP_K1    = 16'(K - 1);
  localparam logic [15:0] LP_LASTC = 16'(IMG_W - 1);
  localparam logic [15:0] LP_LASTR = 16'(IMG_H - 1);

  logic [15:0]     r_col;
  logic [15:0]     r_row;
  logic [LB_W-1:0] r_lb;
  logic [K*K-1:0]  r_win;
  logic [K*K-1:0]  r_patch;
  logic [15:0]     r_out_row;
  logic [15:0]     r_out_col;
  logic            r_valid;
  logic            r_last;

  logic            w_accept;
  logic            w_emit;
  logic            w_eol;
  logic            w_eof;
  logic [K-1:0]    w_new_col;
  logic [K*K-1:0]  w_win_next;

  // Single output register, no skid: a pixel may enter only if the output slot frees this cycle.
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_eol    = (r_col == LP_LASTC);
  assign w_eof    = w_eol && (r_row == LP_LASTR);
  // Column gating keeps wrap-around pixels from the previous row out of any patch.
  assign w_emit   = w_accept && (r_row >= LP_K1) && (r_col >= LP_K1);

  // Bit m of the new column is the pixel m rows above, i.e. accepted m*IMG_W pixels ago.
  always_comb begin
    w_new_col    = '0;
    w_new_col[0] = pix_in;
    for (int m = 1; m < K; m++) begin
      w_new_col[m] = r_lb[m*IMG_W-1];
    end
  end

  always_comb begin
    w_win_next = '0;
    for (int m = 0; m < K; m++) begin
      w_win_next[m*K +: K] = {r_win[m*K +: K-1], w_new_col[m]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_eol) begin
        r_col <= '0;
        r_row <= w_eof ? 16'd0 : r_row + 16'd1;
      end else begin
        r_col <= r_col + 16'd1;
      end
    end
  end

  // History is never emitted before it is rewritten, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb <= {r_lb[LB_W-2:0], pix_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '0;
    end else if (w_accept) begin
      r_win <= w_win_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_patch   <= '0;
      r_out_row <= '0;
      r_out_col <= '0;
      r_last    <= 1'b0;
    end else if (w_emit) begin
      r_valid   <= 1'b1;
      r_patch   <= w_win_next;
      r_out_row <= r_row - LP_K1;
      r_out_col <= r_col - LP_K1;
      r_last    <= w_eof;
    end else if (out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign patch     = r_patch;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;
  assign out_last  = r_last;

endmodule

// File: tb/tb_patch_streamer.sv
// Scoreboard bench for patch_streamer on a 4x4 image with K=3.
// Expected patches come from fixed values or an array-level window model.
module tb_patch_streamer;

  localparam int K = 3;
  localparam int W = 4;
  localparam int H = 4;

  logic         clk;
  logic         rst_n;
  logic         pix_in;
  logic         in_valid;
  logic         in_ready;
  logic [8:0]   patch;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_row;
  logic [15:0]  out_col;
  logic         out_last;

  typedef struct {
    logic [8:0] p;
    int         row;
    int         col;
    bit         last;
  } exp_t;

  exp_t sb[$];
  bit   cur_img[W*H];
  int   n_cmp;
  int   n_bad;
  int   rdy_mode;

  patch_streamer #(.K(K), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .in_valid(in_valid),
    .in_ready(in_ready), .patch(patch), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
    .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // out_ready: 0 = always 1, 1 = random, 2 = held low
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
      else               out_ready = (rdy_mode == 0);
    end
  end

  // Monitor: every handshaked patch is checked against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_patch: got 0x%0h @(%0d,%0d) expected none", patch, out_row, out_col);
        end else begin
          e = sb.pop_front();
          chk("patch", 32'(patch), 32'(e.p));
          chk("out_row", 32'(out_row), 32'(e.row));
          chk("out_col", 32'(out_col), 32'(e.col));
          chk("out_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  task automatic push_exp(input logic [8:0] p, input int r, input int c, input bit l);
    exp_t e;
    e.p = p; e.row = r; e.col = c; e.last = l;
    sb.push_back(e);
  endtask

  task automatic push_checker_const();
    push_exp(9'h155, 0, 0, 1'b0);
    push_exp(9'h0AA, 0, 1, 1'b0);
    push_exp(9'h0AA, 1, 0, 1'b0);
    push_exp(9'h155, 1, 1, 1'b1);
  endtask

  // Reference: cut every KxK sub-image out of the frame, raster order, flattened row-wise
  task automatic push_model();
    logic [8:0] p;
    for (int tr = 0; tr <= H - K; tr++) begin
      for (int tc = 0; tc <= W - K; tc++) begin
        p = '0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            p = {p[7:0], 1'(cur_img[(tr+i)*W + tc + j])};
        push_exp(p, tr, tc, (tr == H - K) && (tc == W - K));
      end
    end
  endtask

  task automatic fill_checker();
    for (int i = 0; i < W*H; i++) cur_img[i] = (((i / W) + (i % W)) % 2) == 0;
  endtask

  task automatic send_pix(input bit b);
    int t;
    bit acc;
    in_valid = 1'b1;
    pix_in   = b;
    t   = 0;
    acc = 1'b0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", t);
    end
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < W*H; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_pix(cur_img[i]);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_cmp++;
    if (sb.size() != 0 || out_valid) begin
      n_bad++;
      $display("FAIL drain: got %0d patches outstanding expected 0", sb.size());
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; rdy_mode = 0;
    rst_n = 1'b0; in_valid = 1'b0; pix_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_patch", 32'(patch), 32'd0);
    chk("rst_out_row", 32'(out_row), 32'd0);
    chk("rst_out_col", 32'(out_col), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Checkerboard with latency check around pixel 10
    fill_checker();
    push_checker_const();
    for (int i = 0; i < W*H; i++) begin
      send_pix(cur_img[i]);
      if (i == 9)  chk("latency_before", 32'(out_valid), 32'd0);
      if (i == 10) chk("latency_first", 32'(out_valid), 32'd1);
    end
    drain();

    // All-ones, then all-zeros
    for (int i = 0; i < W*H; i++) cur_img[i] = 1'b1;
    push_exp(9'h1FF, 0, 0, 1'b0);
    push_exp(9'h1FF, 0, 1, 1'b0);
    push_exp(9'h1FF, 1, 0, 1'b0);
    push_exp(9'h1FF, 1, 1, 1'b1);
    send_frame(1'b0);
    drain();
    for (int i = 0; i < W*H; i++) cur_img[i] = 1'b0;
    push_model();
    send_frame(1'b0);
    drain();

    // Backpressure: hold the first patch, check nothing moves
    fill_checker();
    push_checker_const();
    rdy_mode = 2;
    for (int i = 0; i <= 10; i++) send_pix(cur_img[i]);
    in_valid = 1'b1;
    pix_in   = cur_img[11];
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_patch", 32'(patch), 32'h155);
      chk("hold_row", 32'(out_row), 32'd0);
      chk("hold_col", 32'(out_col), 32'd0);
    end
    rdy_mode = 0;
    for (int i = 11; i < W*H; i++) send_pix(cur_img[i]);
    drain();

    // Row-boundary gating: only column 3 set
    for (int i = 0; i < W*H; i++) cur_img[i] = (i % W) == 3;
    push_exp(9'h000, 0, 0, 1'b0);
    push_exp(9'h049, 0, 1, 1'b0);
    push_exp(9'h000, 1, 0, 1'b0);
    push_exp(9'h049, 1, 1, 1'b1);
    send_frame(1'b0);
    drain();

    // Reset mid-frame with a pending patch; it must vanish
    fill_checker();
    rdy_mode = 2;
    for (int i = 0; i <= 10; i++) send_pix(cur_img[i]);
    chk("pending_before_rst", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_patch", 32'(patch), 32'd0);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    push_checker_const();
    send_frame(1'b0);
    drain();

    // Back-to-back checkerboards with random gaps and random out_ready
    rdy_mode = 1;
    push_checker_const();
    push_checker_const();
    send_frame(1'b1);
    send_frame(1'b1);
    drain();

    // Random images against the window model
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < W*H; i++) cur_img[i] = 1'($urandom_range(0, 1));
      push_model();
      send_frame(1'b1);
    end
    drain();
    rdy_mode = 0;

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
